cache_trace_feeder: RTL and testbench
=====================================

// Module: cache_trace_feeder
// PURPOSE
// - Upstream stimulus stage for cache_top: buffers a host-loaded trace of {op, addr} entries in a FIFO.
// - Replays the trace into the cache address port over a valid/ready handshake, with a programmable inter-request gap.
// - Reports progress (busy, done, issued count) so benches and the top level can read stats when the trace completes.
// PARAMETERS
// - ADDR_W  48  width of a cache address
// - DEPTH   32  FIFO entries; power of 2, >= 2
// - CNT_W   12  width of issued_count, matching the cache stat counters
// - GAP_W    4  width of the gap input
// PORTS
// - clk            in   1          rising-edge clock
// - reset          in   1          asynchronous, active-low reset (0 = reset)
// - load_valid     in   1          host presents a trace entry
// - load_ready     out  1          FIFO can accept an entry (= !full)
// - load_addr      in   ADDR_W     trace address
// - load_op        in   1          0 = read, 1 = write
// - start          in   1          one-cycle pulse; begins replay
// - abort          in   1          one-cycle pulse; flushes FIFO, returns to IDLE
// - gap            in   GAP_W      idle cycles inserted after each accepted request; sampled on start
// - req_valid      out  1          request to cache is valid
// - req_ready      in   1          cache accepts the request
// - req_addr       out  ADDR_W     request address (drives cache_addr)
// - req_op         out  1          request op (drives write_policy/op select)
// - busy           out  1          state == RUN or GAP
// - done           out  1          one-cycle pulse when the last entry is accepted
// - issued_count   out  CNT_W      requests accepted since the last start
// - level          out  log2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
// - Reset (reset=0, async): FIFO empty, pointers 0, state IDLE, gap_q=0, issued_count=0.
// - Reset values: load_ready=1, req_valid=0, req_addr=0, req_op=0, busy=0, done=0, level=0.
// - FIFO: push when load_valid && load_ready; pop when req_valid && req_ready.
// - FIFO: push and pop in the same cycle are both performed, with level unchanged.
// - FIFO: pushes are accepted in every state; pointers wrap modulo DEPTH; full = (level == DEPTH).
// - req_addr/req_op = FIFO head entry; req_addr = 0 and req_op = 0 whenever req_valid = 0.
// - Once req_valid=1, req_addr/req_op stay stable until the handshake completes.
// - FSM IDLE: start && level!=0 -> RUN; gap_q<=gap; issued_count<=0. start with empty FIFO is ignored.
// - FSM RUN: req_valid = (level != 0).
// - RUN handshake, last entry (level==1, no push same cycle): assert done, -> IDLE.
// - RUN handshake, entries remain, gap_q!=0: -> GAP with gap_cnt<=gap_q.
// - RUN handshake, entries remain, gap_q==0: stay in RUN (back-to-back, 1 request/cycle).
// - FSM GAP: req_valid=0; gap_cnt decrements; gap_cnt==1 -> RUN. Total idle = gap_q cycles.
// - Each handshake increments issued_count, wrapping modulo 2^CNT_W.
// - start while busy is ignored; gap changes while busy are ignored.
// - abort (any state, priority over start, push and pop): FIFO cleared, -> IDLE.
// - abort: no done pulse; issued_count is held.
// - Latency: start at edge N -> req_valid=1 from cycle N+1.
// - Async reset mid-replay: immediate return to the reset values above; the buffered trace is lost.
// TESTING
// - Reset: hold reset=0 with load_valid=1 -> load_ready=1, req_valid=0, level=0; no push occurs.
// - Replay: load 20 entries (0x7fff493822b8 first), gap=4, req_ready=1, start.
//   -> 20 handshakes spaced 5 cycles, in load order; done pulse on 20th; issued_count=20; busy=0 after.
// - Backpressure: gap=0, req_ready=0 for 3 cycles on entry 0x0000006324d8.
//   -> req_addr stable, no pop, issued_count unchanged; then 1 request/cycle once req_ready=1.
// - Full: push 32 entries in IDLE -> level=32, load_ready=0; 33rd push dropped.
//   Start and pop one -> load_ready=1; simultaneous push+pop keeps level.
// - Abort: abort after 5 handshakes -> level=0, IDLE, issued_count=5, no done pulse.
//   Start with empty FIFO -> no req_valid.
// - Reset mid-run: drive reset=0 during GAP -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/cache_trace_feeder.sv
// Trace replay stage: buffers {op, addr} entries from a host loader and issues
// them to the cache over valid/ready, with a fixed idle gap after each request.
module cache_trace_feeder #(
    parameter int ADDR_W = 48,
    parameter int DEPTH  = 32,
    parameter int CNT_W  = 12,
    parameter int GAP_W  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              load_op,
    input  logic              start,
    input  logic              abort,
    input  logic [GAP_W-1:0]  gap,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic              req_op,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  issued_count,
    output logic [LVL_W-1:0]  level
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [GAP_W-1:0]   gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [ADDR_W:0]    head;
    logic               full, push, pop;

    always_comb begin
        full       = (level_q == LVL_W'(DEPTH));
        load_ready = !full;
        req_valid  = (state_q == S_RUN) && (level_q != '0);
        push       = load_valid && !full;
        pop        = req_valid && req_ready;
        head       = mem_q[rd_ptr_q];
        // Head is masked so the cache port sees zeros whenever nothing is offered.
        req_addr     = req_valid ? head[ADDR_W-1:0] : '0;
        req_op       = req_valid & head[ADDR_W];
        busy         = (state_q != S_IDLE);
        issued_count = issued_q;
        level        = level_q;
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        issued_d  = issued_q;
        done      = 1'b0;
        if (abort) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);
            unique case (state_q)
                S_IDLE: begin
                    if (start && (level_q != '0)) begin
                        state_d  = S_RUN;
                        gap_d    = gap;
                        issued_d = '0;
                    end
                end
                S_RUN: begin
                    if (pop) begin
                        issued_d = issued_q + CNT_W'(1);
                        if ((level_q == LVL_W'(1)) && !push) begin
                            done    = 1'b1;
                            state_d = S_IDLE;
                        end else if (gap_q != '0) begin
                            state_d   = S_GAP;
                            gap_cnt_d = gap_q;
                        end
                    end
                end
                S_GAP: begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    if (gap_cnt_q == GAP_W'(1)) state_d = S_RUN;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            issued_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            issued_q  <= issued_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by level_q and outputs are masked.
    always_ff @(posedge clk) begin
        if (push && !abort) mem_q[wr_ptr_q] <= {load_op, load_addr};
    end

endmodule

// File: tb/tb_cache_trace_feeder.sv
// Self-checking bench for cache_trace_feeder: randomized traces against a
// transaction-level queue model of the replay behaviour.
module tb_cache_trace_feeder;

    localparam int ADDR_W = 48;
    localparam int DEPTH  = 32;
    localparam int CNT_W  = 12;
    localparam int GAP_W  = 4;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic [ADDR_W-1:0] load_addr = '0;
    logic              load_op = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [GAP_W-1:0]  gap = '0;
    logic              req_valid;
    logic              req_ready = 1'b0;
    logic [ADDR_W-1:0] req_addr;
    logic              req_op;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  issued_count;
    logic [LVL_W-1:0]  level;

    cache_trace_feeder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr), .load_op(load_op),
        .start(start), .abort(abort), .gap(gap),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_op(req_op),
        .busy(busy), .done(done), .issued_count(issued_count), .level(level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending trace, replay flag, remaining idle cycles, stats.
    logic [ADDR_W:0] q[$];
    bit  m_run = 0;
    int  m_idle = 0;
    int  m_gap = 0;
    int  m_issued = 0;
    int  n_hs = 0;
    int  n_done = 0;
    int  cyc_n = 0;
    int  last_hs = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check every output at the falling edge, advance the model.
    task automatic step(input bit lv, input bit lop, input logic [ADDR_W-1:0] la,
                        input bit st, input bit ab, input bit rr, input logic [GAP_W-1:0] g);
        bit ev, acc, hs, dn, was_run;
        logic [ADDR_W:0] hd;
        int sz0;
        load_valid = lv; load_op = lop; load_addr = la;
        start = st; abort = ab; req_ready = rr; gap = g;
        sz0 = q.size();
        ev  = m_run && (m_idle == 0) && (sz0 != 0);
        hd  = ev ? q[0] : '0;
        acc = lv && (sz0 < DEPTH);
        hs  = !ab && ev && rr;
        dn  = hs && (sz0 == 1) && !acc;
        @(negedge clk);
        chk("load_ready", 64'(load_ready), 64'(sz0 < DEPTH));
        chk("level", 64'(level), 64'(sz0));
        chk("req_valid", 64'(req_valid), 64'(ev));
        chk("req_addr", 64'(req_addr), 64'(hd[ADDR_W-1:0]));
        chk("req_op", 64'(req_op), 64'(hd[ADDR_W]));
        chk("busy", 64'(busy), 64'(m_run));
        chk("done", 64'(done), 64'(dn));
        chk("issued_count", 64'(issued_count), 64'(m_issued % (1 << CNT_W)));
        @(posedge clk);
        cyc_n++;
        was_run = m_run;
        if (ab) begin
            q.delete();
            m_run = 0;
        end else begin
            if (hs) begin
                void'(q.pop_front());
                m_issued++;
                n_hs++;
                last_hs = cyc_n;
                if (dn) begin
                    m_run = 0;
                    n_done++;
                end else begin
                    m_idle = m_gap;
                end
            end else if (m_run && m_idle > 0) begin
                m_idle--;
            end
            if (!was_run && st && sz0 != 0) begin
                m_run = 1; m_gap = int'(g); m_issued = 0; m_idle = 0;
            end
            if (acc) q.push_back({lop, la});
        end
        #1;
    endtask

    task automatic idle_step(input bit rr);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, rr, GAP_W'($urandom));
    endtask

    task automatic push_rand();
        step(1'b1, 1'($urandom), {16'($urandom), 32'($urandom)}, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        int prev_hs, hs0, done0, spacing_bad, budget;
        logic [ADDR_W-1:0] a;

        // Reset held with a push attempt: nothing may enter the FIFO.
        load_valid = 1'b1; load_addr = 48'h123456789abc;
        repeat (3) begin
            @(negedge clk);
            chk("rst_load_ready", 64'(load_ready), 64'd1);
            chk("rst_req_valid", 64'(req_valid), 64'd0);
            chk("rst_level", 64'(level), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_issued", 64'(issued_count), 64'd0);
            chk("rst_req_addr", 64'(req_addr), 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1; load_valid = 1'b0;
        idle_step(1'b0);

        // Replay of 20 entries with gap 4; gap input randomised mid-run must be ignored.
        step(1'b1, 1'b1, 48'h7fff493822b8, 1'b0, 1'b0, 1'b0, '0);
        repeat (19) push_rand();
        hs0 = n_hs; done0 = n_done; spacing_bad = 0; prev_hs = -1;
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 4'd4);
        budget = 0;
        while (m_run && budget < 200) begin
            prev_hs = (n_hs > hs0) ? last_hs : prev_hs;
            hs0 = hs0;
            idle_step(1'b1);
            if (last_hs == cyc_n && prev_hs >= 0 && (last_hs - prev_hs) != 5) spacing_bad++;
            budget++;
        end
        chk("replay_timeout", 64'(m_run), 64'd0);
        chk("replay_spacing_errs", 64'(spacing_bad), 64'd0);
        chk("replay_handshakes", 64'(n_hs - hs0), 64'd20);
        chk("replay_done_pulses", 64'(n_done - done0), 64'd1);
        idle_step(1'b0);
        chk("replay_issued", 64'(issued_count), 64'd20);
        chk("replay_busy_after", 64'(busy), 64'd0);

        // Backpressure on the first entry with gap 0, then back-to-back drain.
        step(1'b1, 1'b0, 48'h0000006324d8, 1'b0, 1'b0, 1'b0, '0);
        repeat (5) push_rand();
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd0);
        repeat (3) begin
            idle_step(1'b0);
            chk("bp_addr_hold", 64'(req_addr), 64'h6324d8);
            chk("bp_issued_hold", 64'(issued_count), 64'd0);
        end
        hs0 = n_hs;
        repeat (6) idle_step(1'b1);
        chk("bp_back_to_back", 64'(n_hs - hs0), 64'd6);
        chk("bp_busy_after", 64'(busy), 64'd0);

        // Fill to full, drop the 33rd push, then pop and push+pop.
        repeat (33) push_rand();
        chk("full_level", 64'(level), 64'd32);
        chk("full_load_ready", 64'(load_ready), 64'd0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd0);
        idle_step(1'b1);
        chk("full_after_pop_ready", 64'(load_ready), 64'd1);
        step(1'b1, 1'b1, 48'hcafe0000beef, 1'b0, 1'b0, 1'b1, '0);
        chk("full_pushpop_level", 64'(level), 64'd31);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        chk("full_abort_level", 64'(level), 64'd0);

        // Abort after 5 handshakes, concurrent push and start must be overridden.
        repeat (10) push_rand();
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 4'd2);
        hs0 = n_hs; done0 = n_done; budget = 0;
        while ((n_hs - hs0) < 5 && budget < 100) begin
            idle_step(1'b1);
            budget++;
        end
        chk("abort_reach5", 64'(n_hs - hs0), 64'd5);
        a = {16'($urandom), 32'($urandom)};
        step(1'b1, 1'b0, a, 1'b1, 1'b1, 1'b1, '0);
        chk("abort_level", 64'(level), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_issued_held", 64'(issued_count), 64'd5);
        chk("abort_no_done", 64'(n_done - done0), 64'd0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 4'd1);
        repeat (3) idle_step(1'b1);
        chk("empty_start_no_valid", 64'(req_valid), 64'd0);

        // Asynchronous reset while waiting in the gap.
        repeat (6) push_rand();
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 4'd3);
        idle_step(1'b1);
        idle_step(1'b1);
        chk("mid_busy_before_reset", 64'(busy), 64'd1);
        chk("mid_in_gap", 64'(req_valid), 64'd0);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_issued", 64'(issued_count), 64'd0);
        chk("mid_rst_req_valid", 64'(req_valid), 64'd0);
        chk("mid_rst_load_ready", 64'(load_ready), 64'd1);
        chk("mid_rst_req_addr", 64'(req_addr), 64'd0);
        q.delete(); m_run = 0; m_issued = 0; m_idle = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) idle_step(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
